// File: rtl/fpu_types.sv
// -----------------------------------------------------------------------------
// fpu_types
// Shared FP types for the intermediate writeback path.
//   - fp_wb_intermediate_t : pre-rounded result handed from the arithmetic
//                            units to the writeback round receiver
//   - RM_* constants       : IEEE-754 rounding-mode encodings
//   - FF_* constants       : bit positions inside fflags {NV,DZ,OF,UF,NX}
// No ports (package).
// -----------------------------------------------------------------------------
package fpu_types;

   localparam int FLEN      = 64;   // double format {sign, exp[10:0], mant[51:0]}
   localparam int ID_W      = 3;    // instruction id width
   localparam int GRS_WIDTH = 4;    // guard, round, and two sticky source bits

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   localparam int FF_NX = 0;
   localparam int FF_UF = 1;
   localparam int FF_OF = 2;
   localparam int FF_DZ = 3;
   localparam int FF_NV = 4;

   typedef struct packed {
      logic [ID_W-1:0]      id;
      logic [FLEN-1:0]      rd;
      logic                 expo_overflow;
      logic [4:0]           fflags;
      logic [2:0]           rm;
      logic [GRS_WIDTH-1:0] grs;
      logic                 ignore_max_expo;
      logic                 d2s;
   } fp_wb_intermediate_t;

endpackage

// File: rtl/fp_round_incr.sv
// -----------------------------------------------------------------------------
// fp_round_incr
// Combinational IEEE-754 rounding of a pre-rounded result: round-increment,
// overflow detection and Inf / max-finite substitution.
// Ports:
//   rd              in  FLEN       pre-rounded value (single lives in rd[31:0])
//   grs             in  GRS_WIDTH  guard, round, sticky bits (MSB first)
//   rm              in  3          rounding mode (101-111 behave as RNE)
//   d2s             in  1          1: single-precision result, NaN-boxed
//   expo_overflow   in  1          upstream already detected overflow
//   ignore_max_expo in  1          do not treat an all-ones exponent as overflow
//   result          out FLEN       rounded value
//   of, nx          out 1          overflow / inexact raised by rounding
// -----------------------------------------------------------------------------
module fp_round_incr
   import fpu_types::*;
(
   input  logic [FLEN-1:0]      rd,
   input  logic [GRS_WIDTH-1:0] grs,
   input  logic [2:0]           rm,
   input  logic                 d2s,
   input  logic                 expo_overflow,
   input  logic                 ignore_max_expo,
   output logic [FLEN-1:0]      result,
   output logic                 of,
   output logic                 nx
);

   logic        g, r, s, sign, inc, ovf, to_inf;
   logic [2:0]  rm_eff;
   logic [62:0] dbl_sum;
   logic [30:0] sgl_sum;

   assign g      = grs[GRS_WIDTH-1];
   assign r      = grs[GRS_WIDTH-2];
   assign s      = |grs[GRS_WIDTH-3:0];
   assign sign   = d2s ? rd[31] : rd[63];
   assign rm_eff = (rm > RM_RMM) ? RM_RNE : rm;

   always_comb begin
      inc = 1'b0;
      case (rm_eff)
         RM_RNE:  inc = g & (r | s | rd[0]);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (g | r | s);
         RM_RUP:  inc = ~sign & (g | r | s);
         RM_RMM:  inc = g;
         default: inc = 1'b0;
      endcase
   end

   // Adding over {exp,mant} lets a mantissa carry ripple into the exponent.
   assign dbl_sum = rd[62:0] + {62'd0, inc};
   assign sgl_sum = rd[30:0] + {30'd0, inc};

   assign ovf = expo_overflow |
                (~ignore_max_expo & (d2s ? (&sgl_sum[30:23]) : (&dbl_sum[62:52])));

   // Modes that round away from zero in the direction of the sign give Inf;
   // the rest saturate to the largest finite magnitude.
   assign to_inf = (rm_eff == RM_RNE) | (rm_eff == RM_RMM) |
                   ((rm_eff == RM_RUP) & ~sign) | ((rm_eff == RM_RDN) & sign);

   always_comb begin
      result = '0;
      if (d2s) begin
         if (ovf)
            result = {32'hFFFF_FFFF, sign,
                      (to_inf ? {8'hFF, 23'd0} : {8'hFE, {23{1'b1}}})};
         else
            result = {32'hFFFF_FFFF, sign, sgl_sum};
      end else begin
         if (ovf)
            result = {sign, (to_inf ? {11'h7FF, 52'd0} : {11'h7FE, {52{1'b1}}})};
         else
            result = {sign, dbl_sum};
      end
   end

   assign of = ovf;
   assign nx = g | r | s | ovf;

endmodule

// File: rtl/fp_wb_round_receiver.sv
// -----------------------------------------------------------------------------
// fp_wb_round_receiver
// Receiving end of the FP intermediate writeback interface. Pre-rounded
// results are accepted on done/ack, buffered in a small FIFO, rounded, and
// presented to writeback through an output register on valid/ready.
//
// Optional build macro: FP_WB_BYPASS_EN
//   defined   : an acked input goes straight into the output register when
//               the FIFO is empty and the register can load (1-cycle latency)
//   undefined : every result passes through the FIFO (2-cycle latency)
//
// Ports:
//   clk         in   1        clock
//   rst         in   1        asynchronous, active-low reset
//   in_done     in   1        upstream intermediate result present
//   in_ack      out  1        result consumed this cycle
//   in_data     in   struct   fp_wb_intermediate_t
//   out_valid   out  1        rounded result available
//   out_ready   in   1        writeback accepts result
//   out_id      out  ID_W     instruction id
//   out_rd      out  FLEN     rounded result, NaN-boxed when single
//   out_fflags  out  5        accumulated flags {NV,DZ,OF,UF,NX}
//
// Handshakes: upstream holds in_done and in_data until it sees in_ack; a
// transfer happens on the clock edge where in_ack=1. Downstream, out_valid
// and the out_* payload stay stable until the edge where out_valid &
// out_ready, which is the transfer edge.
// -----------------------------------------------------------------------------
module fp_wb_round_receiver
   import fpu_types::*;
#(
   parameter int FIFO_DEPTH = 2
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_done,
   output logic                in_ack,
   input  fp_wb_intermediate_t in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ID_W-1:0]     out_id,
   output logic [FLEN-1:0]     out_rd,
   output logic [4:0]          out_fflags
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   fp_wb_intermediate_t mem [FIFO_DEPTH];
   fp_wb_intermediate_t src;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic                full, empty, can_load, push, pop, bypass, load;
   logic [FLEN-1:0]     rnd_result;
   logic                rnd_of, rnd_nx;

   // Extra pointer MSB separates full from empty when the index bits match.
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   // Ack looks at the pre-pop state, so a full FIFO refuses even while popping.
   assign in_ack   = rst & in_done & ~full;
   assign can_load = ~out_valid | out_ready;

`ifdef FP_WB_BYPASS_EN
   assign bypass = empty & can_load & in_ack;
   assign src    = empty ? in_data : mem[rd_ptr[AW-1:0]];
`else
   assign bypass = 1'b0;
   assign src    = mem[rd_ptr[AW-1:0]];
`endif

   assign push = in_ack & ~bypass;
   assign pop  = ~empty & can_load;
   assign load = pop | bypass;

   fp_round_incr u_round (
      .rd              (src.rd),
      .grs             (src.grs),
      .rm              (src.rm),
      .d2s             (src.d2s),
      .expo_overflow   (src.expo_overflow),
      .ignore_max_expo (src.ignore_max_expo),
      .result          (rnd_result),
      .of              (rnd_of),
      .nx              (rnd_nx)
   );

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         out_valid  <= 1'b0;
         out_id     <= '0;
         out_rd     <= '0;
         out_fflags <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (load) begin
            out_valid  <= 1'b1;
            out_id     <= src.id;
            out_rd     <= rnd_result;
            out_fflags <= src.fflags | {2'b00, rnd_of, 1'b0, rnd_nx};
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fp_wb_round_receiver.sv
// -----------------------------------------------------------------------------
// tb_fp_wb_round_receiver
// Directed and randomized bench for fp_wb_round_receiver. Expected results
// come from a generic rounding model evaluated on field widths and exponent
// arithmetic, queued in order of acceptance.
// -----------------------------------------------------------------------------
module tb_fp_wb_round_receiver;
   import fpu_types::*;

`ifdef FP_WB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic                in_done = 1'b0;
   logic                in_ack;
   fp_wb_intermediate_t in_data = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [ID_W-1:0]     out_id;
   logic [FLEN-1:0]     out_rd;
   logic [4:0]          out_fflags;

   fp_wb_round_receiver #(.FIFO_DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_done    (in_done),
      .in_ack     (in_ack),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_id     (out_id),
      .out_rd     (out_rd),
      .out_fflags (out_fflags)
   );

   // ---------------- scoreboard ----------------
   int                  checks = 0;
   int                  errors = 0;
   logic [71:0]         exp_q[$];
   logic                last_valid;
   logic [63:0]         last_rd;
   logic [4:0]          last_fl;
   fp_wb_intermediate_t idle = '0;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference rounding: works on the magnitude as an integer with the
   // exponent obtained by shifting out the mantissa width of the format.
   function automatic logic [71:0] model(input fp_wb_intermediate_t d);
      logic        g, r, s, sgn, inc, ovf, to_inf;
      logic [2:0]  m;
      int          mb, eb;
      logic [63:0] mag, emax, res;
      logic [4:0]  fl;
      g   = d.grs[GRS_WIDTH-1];
      r   = d.grs[GRS_WIDTH-2];
      s   = |d.grs[GRS_WIDTH-3:0];
      sgn = d.d2s ? d.rd[31] : d.rd[63];
      mb  = d.d2s ? 23 : 52;
      eb  = d.d2s ? 8 : 11;
      mag = d.d2s ? {33'd0, d.rd[30:0]} : {1'b0, d.rd[62:0]};
      m   = (d.rm > RM_RMM) ? RM_RNE : d.rm;
      case (m)
         RM_RNE:  inc = g & (r | s | d.rd[0]);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sgn & (g | r | s);
         RM_RUP:  inc = !sgn & (g | r | s);
         default: inc = g;
      endcase
      mag  = mag + 64'(inc);
      emax = (64'd1 << eb) - 64'd1;
      ovf  = d.expo_overflow || (((mag >> mb) == emax) && !d.ignore_max_expo);
      if (ovf) begin
         to_inf = (m == RM_RNE) || (m == RM_RMM) || (m == RM_RUP && !sgn) || (m == RM_RDN && sgn);
         mag = to_inf ? (emax << mb) : (((emax - 64'd1) << mb) | ((64'd1 << mb) - 64'd1));
      end
      res = d.d2s ? {32'hFFFF_FFFF, sgn, mag[30:0]} : {sgn, mag[62:0]};
      fl  = d.fflags;
      if (g | r | s) fl[FF_NX] = 1'b1;
      if (ovf) begin
         fl[FF_OF] = 1'b1;
         fl[FF_NX] = 1'b1;
      end
      return {d.id, fl, res};
   endfunction

   function automatic fp_wb_intermediate_t mk(input logic [2:0] id, input logic [63:0] rd,
                                              input logic [3:0] grs, input logic [2:0] rm,
                                              input logic d2s, input logic eo);
      fp_wb_intermediate_t d;
      d = '0;
      d.id = id; d.rd = rd; d.grs = grs; d.rm = rm; d.d2s = d2s; d.expo_overflow = eo;
      return d;
   endfunction

   function automatic fp_wb_intermediate_t rnd_item();
      fp_wb_intermediate_t d;
      d.id              = 3'($urandom);
      d.rd              = {$urandom, $urandom};
      d.expo_overflow   = ($urandom_range(0, 7) == 0);
      d.fflags          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      d.rm              = 3'($urandom);
      d.grs             = 4'($urandom);
      d.ignore_max_expo = ($urandom_range(0, 3) == 0);
      d.d2s             = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
         if (d.d2s) d.rd[30:0] = {8'hFE, 23'h7F_FFFF};
         else       d.rd[62:0] = {11'h7FE, 52'hF_FFFF_FFFF_FFFF};
      end
      return d;
   endfunction

   // ---------------- driver ----------------
   // One cycle: drive at negedge, sample #1 later, then let the posedge happen.
   task automatic step(input logic done, input fp_wb_intermediate_t d, input logic ready,
                       output logic acked);
      @(negedge clk);
      in_done   = done;
      in_data   = d;
      out_ready = ready;
      #1;
      acked      = in_ack;
      last_valid = out_valid;
      last_rd    = out_rd;
      last_fl    = out_fflags;
      if (in_ack) exp_q.push_back(model(d));
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("spurious_out", 72'(out_valid), 72'd0);
         else check("result", {out_id, out_fflags, out_rd}, exp_q.pop_front());
      end
   endtask

   task automatic run_one(input string tag, input fp_wb_intermediate_t d,
                          input logic [63:0] erd, input logic [4:0] efl);
      logic acked;
      int   n;
      step(1'b1, d, 1'b1, acked);
      check({tag, "_ack"}, 72'(acked), 72'd1);
      n = 0;
      last_valid = 1'b0;
      while (!last_valid && n < 8) begin
         step(1'b0, idle, 1'b1, acked);
         n++;
      end
      check({tag, "_lat"}, 72'(n), 72'(LAT));
      check({tag, "_rd"}, 72'(last_rd), 72'(erd));
      check({tag, "_fl"}, 72'(last_fl), 72'(efl));
   endtask

   task automatic drain(input string tag);
      logic acked;
      int   n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         step(1'b0, idle, 1'b1, acked);
         n++;
      end
      check(tag, 72'(exp_q.size()), 72'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic                acked;
      logic                pend;
      fp_wb_intermediate_t cur;

      // Reset state, with in_done already high.
      in_done = 1'b1;
      #12;
      check("rst_valid", 72'(out_valid), 72'd0);
      check("rst_id", 72'(out_id), 72'd0);
      check("rst_rd", 72'(out_rd), 72'd0);
      check("rst_fflags", 72'(out_fflags), 72'd0);
      check("rst_ack", 72'(in_ack), 72'd0);
      in_done = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Directed rounding cases.
      run_one("rne_tie", mk(3'd1, 64'h3FF0_0000_0000_0001, 4'b1000, RM_RNE, 1'b0, 1'b0),
              64'h3FF0_0000_0000_0002, 5'b00001);
      run_one("rtz", mk(3'd2, 64'h3FF0_0000_0000_0000, 4'b1000, RM_RTZ, 1'b0, 1'b0),
              64'h3FF0_0000_0000_0000, 5'b00001);
      run_one("rup", mk(3'd3, 64'h3FF0_0000_0000_0000, 4'b1000, RM_RUP, 1'b0, 1'b0),
              64'h3FF0_0000_0000_0001, 5'b00001);
      run_one("ovf_rne", mk(3'd4, 64'h7FEF_FFFF_FFFF_FFFF, 4'b1000, RM_RNE, 1'b0, 1'b0),
              64'h7FF0_0000_0000_0000, 5'b00101);
      run_one("ovf_rtz", mk(3'd5, 64'h7FEF_FFFF_FFFF_FFFF, 4'b1000, RM_RTZ, 1'b0, 1'b1),
              64'h7FEF_FFFF_FFFF_FFFF, 5'b00101);
      run_one("single", mk(3'd6, 64'h0000_0000_3F80_0000, 4'b1100, RM_RNE, 1'b1, 1'b0),
              64'hFFFF_FFFF_3F80_0001, 5'b00001);

      // Randomized traffic with backpressure; data held until acked.
      pend = 1'b0;
      cur  = idle;
      for (int i = 0; i < 400; i++) begin
         if (!pend) begin
            pend = 1'($urandom_range(0, 1));
            cur  = rnd_item();
         end
         step(pend, cur, ($urandom_range(0, 3) != 0), acked);
         if (acked) pend = 1'b0;
      end
      drain("rand_drain");

      // Fill: one result in the output register, two in the FIFO.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, mk(3'(i), 64'h4000_0000_0000_0000 + 64'(i), 4'b0100, RM_RNE, 1'b0, 1'b0),
              1'b0, acked);
         check("fill_ack", 72'(acked), 72'd1);
      end
      cur = mk(3'd7, 64'h4010_0000_0000_0000, 4'b0000, RM_RTZ, 1'b0, 1'b0);
      step(1'b1, cur, 1'b0, acked);
      check("full_refuse", 72'(acked), 72'd0);
      step(1'b1, cur, 1'b1, acked);
      check("full_pop_refuse", 72'(acked), 72'd0);
      drain("full_drain");

      // Async reset with two entries buffered.
      for (int i = 0; i < 3; i++)
         step(1'b1, mk(3'(i + 1), {$urandom, $urandom}, 4'($urandom), RM_RNE, 1'b0, 1'b0),
              1'b0, acked);
      @(negedge clk);
      in_done = 1'b1;
      out_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 72'(out_valid), 72'd0);
      check("mid_rst_ack", 72'(in_ack), 72'd0);
      exp_q.delete();
      in_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_one("post_rst", mk(3'd2, 64'hC000_0000_0000_0000, 4'b0011, RM_RDN, 1'b0, 1'b0),
              64'hC000_0000_0000_0001, 5'b00001);
      drain("final_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
